// File: rtl/inst_fetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package inst_fetch_buf_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_W-1:0]      NOP_INST         = 32'h0000_0013;
    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] addr;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] next_word(input logic [INST_ADDR_W-1:0] a);
        return a + INST_ADDR_W'(4);
    endfunction

endpackage

// File: rtl/inst_fetch_buf_fifo.sv
// ifb_fifo: generic synchronous FIFO with push/pop/flush, occupancy count and head output.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifb_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    // Pointer and occupancy state; flush empties the queue in one edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction prefetch buffer: owns the fetch PC, tracks in-flight fetches and queues tagged instructions.
// Optional zero-latency bypass of an empty queue is enabled with `define IFB_BYPASS_EN.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_OUTSTD = 2,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o,
    input  logic        inst_ready_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTD) + 1;
    localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    logic                   started;
    logic [31:0]            fpc, fpc_nxt;
    logic [31:0]            rpc, rpc_nxt;
    logic [OUT_W-1:0]       outstd, outstd_nxt;
    logic [OUT_W-1:0]       drop_cnt, drop_cnt_nxt;
    logic [CNT_W-1:0]       count;
    logic                   fifo_empty;
    logic                   fifo_push, fifo_pop;
    fetch_entry_t           head, push_entry;
    logic [31:0]            flush_tgt;
    logic                   fire, rsp_ok, rsp_drop, rsp_keep, byp, byp_take;

    assign flush_tgt = flush_pc_i & ~32'h0000_0003;

    // Space is reserved at request time so a returning response always has a slot.
    assign imem_req_o  = started && !flush_i
                         && ((SUM_W'(count) + SUM_W'(outstd)) < SUM_W'(DEPTH))
                         && (outstd < OUT_W'(MAX_OUTSTD));
    assign imem_addr_o = fpc;

    assign fire     = imem_req_o && imem_gnt_i;
    assign rsp_ok   = imem_rvalid_i && (outstd != '0);
    assign rsp_drop = rsp_ok && (drop_cnt != '0);
    assign rsp_keep = rsp_ok && (drop_cnt == '0);

`ifdef IFB_BYPASS_EN
    assign byp = rsp_keep && fifo_empty && !flush_i;
`else
    assign byp = 1'b0;
`endif
    assign byp_take = byp && inst_ready_i;

    assign push_entry = '{addr: rpc, inst: imem_rdata_i};
    assign fifo_push  = rsp_keep && !flush_i && !byp_take;
    assign fifo_pop   = !fifo_empty && inst_ready_i && !flush_i;

    always_comb begin
        fpc_nxt      = fpc;
        rpc_nxt      = rpc;
        outstd_nxt   = outstd + OUT_W'(fire) - OUT_W'(rsp_ok);
        drop_cnt_nxt = drop_cnt;
        if (flush_i) begin
            fpc_nxt      = flush_tgt;
            rpc_nxt      = flush_tgt;
            // Everything still in flight after this edge is stale.
            drop_cnt_nxt = outstd - OUT_W'(rsp_ok);
        end else begin
            if (fire)     fpc_nxt      = next_word(fpc);
            if (rsp_keep) rpc_nxt      = next_word(rpc);
            if (rsp_drop) drop_cnt_nxt = drop_cnt - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            started  <= 1'b0;
            fpc      <= RESET_PC;
            rpc      <= RESET_PC;
            outstd   <= '0;
            drop_cnt <= '0;
        end else begin
            started  <= 1'b1;
            fpc      <= fpc_nxt;
            rpc      <= rpc_nxt;
            outstd   <= outstd_nxt;
            drop_cnt <= drop_cnt_nxt;
        end
    end

    ifb_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head),
        .count (count),
        .empty (fifo_empty)
    );

    // Head of queue, or the bypassed response when the queue is empty.
    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = NOP_INST;
        instaddr_o   = '0;
        if (!fifo_empty) begin
            inst_valid_o = 1'b1;
            inst_o       = head.inst;
            instaddr_o   = head.addr;
        end else if (byp) begin
            inst_valid_o = 1'b1;
            inst_o       = imem_rdata_i;
            instaddr_o   = rpc;
        end
    end

    rsp_without_fetch: assert property (@(posedge clk) disable iff (!rstn)
        imem_rvalid_i |-> (outstd != '0));

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed self-checking bench for inst_fetch_buf; memory returns ~addr one cycle after grant, in order.
module tb_inst_fetch_buf;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] instaddr_o;
    logic        inst_ready_i;

    inst_fetch_buf dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .instaddr_o    (instaddr_o),
        .inst_ready_i  (inst_ready_i)
    );

    always #5 clk = ~clk;

`ifdef IFB_BYPASS_EN
    localparam int BYP_LAT = 0;
`else
    localparam int BYP_LAT = 1;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    int          fires = 0;
    logic [31:0] pend[$];
    logic [31:0] exp_fpc;

    // stimulus controls
    logic        gnt_en, rsp_en, ready_en, flush_req;
    logic [31:0] flush_tgt;

    // pre-edge observations of the last cycle
    logic        o_req, o_valid, o_rsp;
    logic [31:0] o_addr, o_inst, o_iaddr, o_rsp_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, observe before posedge, update memory model at posedge.
    task automatic cycle();
        logic fired;
        @(negedge clk);
        imem_gnt_i   = gnt_en;
        inst_ready_i = ready_en;
        flush_i      = flush_req;
        flush_pc_i   = flush_tgt;
        if (rsp_en && pend.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = ~pend[0];
            o_rsp_addr    = pend[0];
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
            o_rsp_addr    = 32'h0;
        end
        #1;
        o_req   = imem_req_o;
        o_addr  = imem_addr_o;
        o_valid = inst_valid_o;
        o_inst  = inst_o;
        o_iaddr = instaddr_o;
        o_rsp   = imem_rvalid_i;
        fired   = imem_req_o && imem_gnt_i;
        if (fired) begin
            check_eq("fetch_addr", imem_addr_o, exp_fpc);
            exp_fpc = exp_fpc + 32'd4;
            fires++;
        end
        if (flush_i) exp_fpc = flush_pc_i & ~32'h3;
        @(posedge clk);
        if (o_rsp) void'(pend.pop_front());
        if (fired) pend.push_back(o_addr);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        gnt_en = 1'b0; rsp_en = 1'b0; ready_en = 1'b0; flush_req = 1'b0; flush_tgt = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        inst_ready_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
        #1;
        check_eq("rst_req", imem_req_o, 0);
        check_eq("rst_valid", inst_valid_o, 0);
        check_eq("rst_inst", inst_o, 32'h0000_0013);
        check_eq("rst_iaddr", instaddr_o, 0);
        check_eq("rst_addr", imem_addr_o, 0);
        pend.delete();
        exp_fpc = 32'h0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Expect n consumed outputs with consecutive addresses from start, within budget cycles.
    task automatic expect_stream(input string tag, input logic [31:0] start, input int n, input int budget);
        logic [31:0] a;
        int got;
        a = start;
        got = 0;
        for (int k = 0; k < budget && got < n; k++) begin
            cycle();
            if (o_valid && ready_en) begin
                check_eq({tag, "_iaddr"}, o_iaddr, a);
                check_eq({tag, "_inst"}, o_inst, ~a);
                a = a + 32'd4;
                got++;
            end
        end
        check_eq({tag, "_count"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int f0, rcyc, vcyc;
        logic found;

        // T1: streaming, one instruction per cycle once filled
        do_reset();
        ready_en = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (o_valid) begin found = 1'b1; break; end
        end
        check_eq("t1_first_valid", found, 1);
        check_eq("t1_iaddr0", o_iaddr, 32'h0);
        check_eq("t1_inst0", o_inst, ~32'h0);
        for (int i = 1; i < 8; i++) begin
            cycle();
            check_eq("t1_valid", o_valid, 1);
            check_eq("t1_iaddr", o_iaddr, 32'(4 * i));
            check_eq("t1_inst", o_inst, ~32'(4 * i));
        end

        // T2: hold from reset fills exactly DEPTH entries, then drains in order
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; ready_en = 1'b0;
        f0 = fires;
        repeat (12) cycle();
        check_eq("t2_grants", fires - f0, 4);
        check_eq("t2_req_low", o_req, 0);
        check_eq("t2_head_valid", o_valid, 1);
        check_eq("t2_head_iaddr", o_iaddr, 32'h0);
        ready_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("t2_drain_valid", o_valid, 1);
            check_eq("t2_drain_iaddr", o_iaddr, 32'(4 * i));
            check_eq("t2_drain_inst", o_inst, ~32'(4 * i));
        end

        // T3: flush with 0x8/0xC outstanding drops both, restarts at 0x100
        do_reset();
        ready_en = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0;
        repeat (5) cycle();
        gnt_en = 1'b0; rsp_en = 1'b1;
        expect_stream("t3_pre", 32'h0, 2, 8);
        gnt_en = 1'b1; rsp_en = 1'b0;
        f0 = fires;
        repeat (4) cycle();
        check_eq("t3_outstd_grants", fires - f0, 2);
        flush_req = 1'b1; flush_tgt = 32'h0000_0103;
        cycle();
        check_eq("t3_flush_req", o_req, 0);
        flush_req = 1'b0; rsp_en = 1'b1;
        expect_stream("t3_post", 32'h100, 2, 20);

        // T4: flush coinciding with a response, two outstanding
        do_reset();
        ready_en = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0;
        f0 = fires;
        repeat (5) cycle();
        check_eq("t4_grants", fires - f0, 2);
        flush_req = 1'b1; flush_tgt = 32'h0000_0100; rsp_en = 1'b1;
        cycle();
        check_eq("t4_flush_rsp", o_rsp, 1);
        check_eq("t4_flush_req", o_req, 0);
        flush_req = 1'b0;
        expect_stream("t4_post", 32'h100, 2, 20);

        // T5: grant withheld keeps the request stable
        do_reset();
        gnt_en = 1'b0; rsp_en = 1'b1; ready_en = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("t5_req", o_req, 1);
            check_eq("t5_addr", o_addr, 32'h0);
            check_eq("t5_valid", o_valid, 0);
            check_eq("t5_nop", o_inst, 32'h0000_0013);
            check_eq("t5_iaddr", o_iaddr, 32'h0);
        end
        gnt_en = 1'b1;
        expect_stream("t5_post", 32'h0, 3, 12);

        // T6: flush to the top word, wrap to 0, check response-to-valid latency
        do_reset();
        ready_en = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
        expect_stream("t6_pre", 32'h0, 3, 12);
        flush_req = 1'b1; flush_tgt = 32'hFFFF_FFFE;
        cycle();
        flush_req = 1'b0;
        rcyc = -1; vcyc = -1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (o_rsp && o_rsp_addr == 32'hFFFF_FFFC && rcyc < 0) rcyc = k;
            if (o_valid) begin
                vcyc = k;
                check_eq("t6_top_iaddr", o_iaddr, 32'hFFFF_FFFC);
                check_eq("t6_top_inst", o_inst, 32'h0000_0003);
                break;
            end
        end
        check_eq("t6_rsp_seen", (rcyc >= 0), 1);
        check_eq("t6_latency", 32'(vcyc - rcyc), 32'(BYP_LAT));
        expect_stream("t6_wrap", 32'h0, 2, 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buf.md
Name: inst_fetch_buf

Overview:
Instruction prefetch buffer between the instruction memory port and the IF/ID pipeline register of riscv_core.
- Owns the fetch PC and issues word fetches over a request/grant/response handshake.
- Queues returned instructions, each tagged with its address, in a small FIFO.
- Presents them to if_id with valid/ready, and discards stale fetches on a redirect (jump or prediction fail).

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_OUTSTD, 2, max granted-but-unanswered fetches (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all flops rising edge
rstn  in  1  asynchronous active-low reset
flush_i  in  1  redirect pulse from ctrl/pc logic
flush_pc_i  in  32  redirect target; bits[1:0] ignored (forced 0)
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch word address (= fetch PC)
imem_gnt_i  in  1  request accepted this cycle (qualified by imem_req_o)
imem_rvalid_i  in  1  response valid; responses return in order
imem_rdata_i  in  32  response instruction word
inst_valid_o  out  1  FIFO head valid
inst_o  out  32  head instruction; 32'h0000_0013 (NOP) when not valid
instaddr_o  out  32  head instruction address; 0 when not valid
inst_ready_i  in  1  consumer accepts head (low while pipeline hold active)

Behaviour:
- Reset values (async): fpc = RESET_PC, rpc = RESET_PC, FIFO count = 0, outstd = 0, drop_cnt = 0, imem_req_o = 0, inst_valid_o = 0, inst_o = NOP, instaddr_o = 0.
- Request rule: imem_req_o = !flush_i && (count + outstd < DEPTH) && (outstd < MAX_OUTSTD).
  - The space reservation guarantees a response never finds the FIFO full.
  - imem_addr_o = fpc.
  - req+gnt: fpc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), outstd++.
- Response:
  - rvalid with drop_cnt > 0: data discarded, drop_cnt--, outstd--.
  - rvalid with drop_cnt == 0: push {rpc, rdata}, rpc += 4, outstd--.
  - rvalid while outstd == 0 is a protocol error: ignored, and an assertion fires.
- Pop: inst_valid_o && inst_ready_i removes the head at the clock edge.
- Push and pop in the same cycle: count unchanged. Works at both full and empty; empty only with IFB_BYPASS_EN, see below.
- Latency without bypass: response at edge N, inst_valid_o high after edge N. Sustained throughput is 1 instr/cycle when gnt is always high and rvalid arrives the cycle after gnt.
- Flush (highest priority, takes effect at the edge):
  - FIFO emptied, count = 0.
  - fpc = rpc = {flush_pc_i[31:2], 2'b00}.
  - drop_cnt = outstd - rvalid_this_cycle (any response arriving in the flush cycle is discarded).
  - imem_req_o forced low in the flush cycle, so no gnt is counted.
  - A pop in the same cycle is ignored.
  - Fetch at the new PC is requested the cycle after flush.
  - Back-to-back flushes: the last one wins; drop_cnt recomputed from the current outstd.
- Hold: inst_ready_i low freezes the head. Prefetch continues until the FIFO plus in-flight fetches reach DEPTH, then stops.
- Reset mid-operation: all state cleared asynchronously. The memory is reset by the same rstn, so no stale responses are expected.
- Counters:
  - count is log2(DEPTH)+1 bits.
  - outstd and drop_cnt are log2(MAX_OUTSTD)+1 bits.
  - FIFO pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
IFB_BYPASS_EN
- Defined: when the FIFO is empty, drop_cnt == 0 and no flush, an arriving response drives inst_valid_o/inst_o/instaddr_o combinationally in the same cycle (zero-latency).
  - inst_ready_i high: the response is consumed and not pushed.
  - inst_ready_i low: the response is pushed normally.
- Undefined: a response is always written to the FIFO first, giving a minimum 1-cycle latency; the outputs are driven only from registered FIFO state.

Decomposition:
- Shared package/defines: NOP encoding 32'h0000_0013, InstAddrBus/InstBus widths, RESET_PC default.
- One sub-module: ifb_fifo, a generic synchronous FIFO with push/pop/flush, count and head outputs, parameterised by width (64: addr+inst) and DEPTH.
- Fetch PC, outstanding/drop counters, request logic and bypass stay in inst_fetch_buf.

Test Plan:
1. Reset release, gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> addresses 0x0,0x4,0x8... issued; inst_valid_o streams with instaddr_o 0x0,0x4,... one per cycle, no gaps after fill.
2. ready=0 from reset, DEPTH=4 -> exactly 4 requests granted, then imem_req_o low; FIFO count=4; raising ready drains 0x0..0xC in order.
3. Two fetches outstanding (0x8, 0xC), flush_i with flush_pc_i=0x103 -> both responses dropped, next request addr 0x100, first output instaddr_o=0x100.
4. Flush in the same cycle as rvalid with outstd=2 -> that response dropped, drop_cnt=1, one further response dropped, FIFO empty until the 0x100 response.
5. gnt withheld for 5 cycles -> imem_req_o and imem_addr_o stable, fpc unchanged, no spurious push.
6. fpc=0xFFFF_FFFC granted -> next address 0x0 (wrap); with IFB_BYPASS_EN, an empty FIFO plus ready=1 gives inst_valid_o in the same cycle as rvalid.
